sram_beat_slave: RTL and testbench

Physical-side responder for the 48-bit beat protocol (stb / addr / 6-bit byte-mask / nak) driven by the line-burst SRAM wrapper.
- Accepts one 48-bit beat at a time.
- Drives three parallel 16-bit asynchronous SRAM chips with per-chip strobes.
- Returns read data on the same beat interface, using nak as the busy/ready indication.
- Sits between the burst wrapper and the board SRAM pins.

---
 rtl/sram_beat_slave_if.sv | 16 +
 rtl/sram_beat_slave.sv | 123 ++++++++++++
 tb/tb_sram_beat_slave.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_beat_slave_if.sv
// Beat-protocol bundle between the line-burst wrapper (master) and the SRAM
// responder (slave): one 48-bit beat at a time, nak doubles as busy.
`timescale 1ns/1ps
interface sram_beat_slave_if;
   logic        wb_stb;
   logic [31:0] wb_addr;
   logic [5:0]  wb_we;
   logic [47:0] wb_din;
   logic [47:0] wb_dout;
   logic        wb_nak;

   modport master (output wb_stb, wb_addr, wb_we, wb_din,
                   input  wb_dout, wb_nak);
   modport slave  (input  wb_stb, wb_addr, wb_we, wb_din,
                   output wb_dout, wb_nak);
endinterface

// File: rtl/sram_beat_slave.sv
// Physical-side responder: turns one accepted 48-bit beat into a timed read or
// write cycle on three parallel 16-bit asynchronous SRAM chips.
`timescale 1ns/1ps
module sram_beat_slave #(
   parameter int T_ACC = 2,
   parameter int T_WR  = 2
) (
   input  logic             clkCPU,
   input  logic             rst_n,
   sram_beat_slave_if.slave bus,
   output logic [2:0]       sram_ce_n,
   output logic [2:0]       sram_oe_n,
   output logic [2:0]       sram_we_n,
   output logic [2:0]       sram_ub_n,
   output logic [2:0]       sram_lb_n,
   output logic [19:0]      sram_addr,
   inout  wire  [47:0]      sram_data
);
   localparam int NUM_LANES = 3;
   localparam int VEC_W     = 16;

   typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

   state_t                               state;
   logic [3:0]                           cnt;
   logic [NUM_LANES-1:0][VEC_W-1:0]      din_q;
   logic                                 drv;
   logic                                 nak_q;
   logic [47:0]                          dout_q;
   logic [NUM_LANES-1:0]                 lane_lb_n;
   logic [NUM_LANES-1:0]                 lane_ub_n;
   logic                                 is_read;
   logic                                 unused_addr_bits;

   // Each chip gets its byte strobes from its own pair of mask bits.
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign lane_lb_n[i] = ~bus.wb_we[2*i];
      assign lane_ub_n[i] = ~bus.wb_we[2*i+1];
   end

   assign is_read          = (bus.wb_we == 6'd0);
   assign unused_addr_bits = ^{bus.wb_addr[31:22], bus.wb_addr[1:0]};

   // drv is only set in write states, where every oe_n is high.
   assign sram_data   = drv ? din_q : {(NUM_LANES*VEC_W){1'bz}};
   assign bus.wb_nak  = nak_q;
   assign bus.wb_dout = dout_q;

   always_ff @(posedge clkCPU) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         din_q     <= '0;
         drv       <= 1'b0;
         nak_q     <= 1'b0;
         dout_q    <= 48'd0;
         sram_ce_n <= 3'b111;
         sram_oe_n <= 3'b111;
         sram_we_n <= 3'b111;
         sram_ub_n <= 3'b111;
         sram_lb_n <= 3'b111;
         sram_addr <= 20'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.wb_stb) begin
                  nak_q     <= 1'b1;
                  sram_addr <= bus.wb_addr[21:2];
                  din_q     <= bus.wb_din;
                  sram_ce_n <= 3'b000;
                  if (is_read) begin
                     state     <= RD;
                     cnt       <= 4'(T_ACC - 1);
                     sram_oe_n <= 3'b000;
                     sram_ub_n <= 3'b000;
                     sram_lb_n <= 3'b000;
                  end else begin
                     state     <= WR_SETUP;
                     sram_ub_n <= lane_ub_n;
                     sram_lb_n <= lane_lb_n;
                     drv       <= 1'b1;
                  end
               end
            end
            RD: begin
               if (cnt == 4'd0) begin
                  dout_q    <= sram_data;
                  nak_q     <= 1'b0;
                  sram_ce_n <= 3'b111;
                  sram_oe_n <= 3'b111;
                  sram_ub_n <= 3'b111;
                  sram_lb_n <= 3'b111;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            WR_SETUP: begin
               sram_we_n <= 3'b000;
               cnt       <= 4'(T_WR - 1);
               state     <= WR_PULSE;
            end
            WR_PULSE: begin
               if (cnt == 4'd0) begin
                  sram_we_n <= 3'b111;
                  state     <= WR_HOLD;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            WR_HOLD: begin
               nak_q     <= 1'b0;
               drv       <= 1'b0;
               sram_ce_n <= 3'b111;
               sram_ub_n <= 3'b111;
               sram_lb_n <= 3'b111;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_beat_slave.sv
// Directed bench for sram_beat_slave: vector table of beats against a
// cycle-level async SRAM model, plus burst and mid-write reset sequences.
`timescale 1ns/1ps
module tb_sram_beat_slave;
   localparam int T_ACC = 2;
   localparam int T_WR  = 2;

   logic clkCPU = 1'b0;
   logic rst_n  = 1'b0;
   always #5 clkCPU = ~clkCPU;

   sram_beat_slave_if bus();
   logic [2:0]  ce_n, oe_n, we_n, ub_n, lb_n;
   logic [19:0] saddr;
   wire  [47:0] sram_data;

   sram_beat_slave #(.T_ACC(T_ACC), .T_WR(T_WR)) dut (
      .clkCPU   (clkCPU),
      .rst_n    (rst_n),
      .bus      (bus),
      .sram_ce_n(ce_n),
      .sram_oe_n(oe_n),
      .sram_we_n(we_n),
      .sram_ub_n(ub_n),
      .sram_lb_n(lb_n),
      .sram_addr(saddr),
      .sram_data(sram_data)
   );

   // SRAM model: combinational read; a write lands only if we_n stayed low
   // for at least T_WR cycles, so an aborted pulse leaves memory untouched.
   logic [47:0] mem [0:(1<<20)-1];
   logic [47:0] rd_word;
   assign rd_word   = mem[saddr];
   assign sram_data = (ce_n == 3'b000 && oe_n == 3'b000 && we_n == 3'b111) ? rd_word : 48'hzzzz_zzzz_zzzz;

   int          lowc [3];
   logic [19:0] wa_l [3];
   logic [15:0] wd_l [3];
   logic        lb_l [3];
   logic        ub_l [3];

   always @(posedge clkCPU) begin
      for (int i = 0; i < 3; i++) begin
         if (!we_n[i] && !ce_n[i]) begin
            lowc[i] <= lowc[i] + 1;
            wa_l[i] <= saddr;
            wd_l[i] <= sram_data[16*i +: 16];
            lb_l[i] <= lb_n[i];
            ub_l[i] <= ub_n[i];
         end else begin
            if (lowc[i] >= T_WR) begin
               if (!lb_l[i]) mem[wa_l[i]][16*i +: 8]   <= wd_l[i][7:0];
               if (!ub_l[i]) mem[wa_l[i]][16*i+8 +: 8] <= wd_l[i][15:8];
            end
            lowc[i] <= 0;
         end
      end
   end

   int cont_bad = 0;
   always @(negedge clkCPU)
      if (rst_n && oe_n != 3'b111 && we_n != 3'b111) cont_bad++;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [5:0]  mask;
      logic [47:0] din;
      logic [19:0] exp_sa;
      logic [2:0]  exp_lb;
      logic [2:0]  exp_ub;
      logic [47:0] exp_dout;
   } vec_t;

   // Entry is #1 after an edge with the slave idle.
   task automatic run_vec(input vec_t v);
      int n, wlow, wfirst, olow, exp_lat;
      bus.wb_stb  = 1'b1;
      bus.wb_addr = v.addr;
      bus.wb_we   = v.mask;
      bus.wb_din  = v.din;
      @(posedge clkCPU); #1;
      bus.wb_stb = 1'b0;
      chk("accept_nak", bus.wb_nak, 1);
      chk("sram_addr", saddr, v.exp_sa);
      chk("lb_n", lb_n, v.exp_lb);
      chk("ub_n", ub_n, v.exp_ub);
      chk("ce_n_active", ce_n, 3'b000);
      n = 0; wlow = 0; wfirst = -1;
      olow = (oe_n == 3'b000) ? 1 : 0;
      while (bus.wb_nak && n < 40) begin
         @(posedge clkCPU); #1;
         n++;
         if (we_n == 3'b000) begin
            wlow++;
            if (wfirst < 0) wfirst = n;
         end
         if (oe_n == 3'b000) olow++;
      end
      exp_lat = (v.mask == 6'd0) ? T_ACC : T_WR + 2;
      chk("latency", n, exp_lat);
      if (v.mask == 6'd0) begin
         chk("oe_low_cycles", olow, T_ACC);
      end else begin
         chk("we_low_cycles", wlow, T_WR);
         chk("we_first", wfirst, 1);
      end
      chk("wb_dout", bus.wb_dout, v.exp_dout);
      chk("ce_n_idle", ce_n, 3'b111);
   endtask

   vec_t vt [8];

   initial begin
      int acc, done, cyc, last;
      logic nak_pre, stb_pre;

      vt[0] = '{32'h0000_0010, 6'h3F,      48'hA5A5_1234_5678, 20'h00004, 3'b000, 3'b000, 48'h000F_BEEF_002D};
      vt[1] = '{32'h0000_0010, 6'h00,      48'h0,              20'h00004, 3'b000, 3'b000, 48'hA5A5_1234_5678};
      vt[2] = '{32'h0000_0010, 6'b000110,  48'hFFFF_FFFF_FFFF, 20'h00004, 3'b101, 3'b110, 48'hA5A5_1234_5678};
      vt[3] = '{32'h0000_0010, 6'h00,      48'h0,              20'h00004, 3'b000, 3'b000, 48'hA5A5_12FF_FF78};
      vt[4] = '{32'h003F_FFFC, 6'h3F,      48'h1111_2222_3333, 20'hFFFFF, 3'b000, 3'b000, 48'hA5A5_12FF_FF78};
      vt[5] = '{32'h0040_0000, 6'h00,      48'h0,              20'h00000, 3'b000, 3'b000, 48'h0000_BEEF_0000};
      vt[6] = '{32'hFFFF_FFFF, 6'h00,      48'h0,              20'hFFFFF, 3'b000, 3'b000, 48'h1111_2222_3333};
      vt[7] = '{32'h0000_0014, 6'h00,      48'h0,              20'h00005, 3'b000, 3'b000, 48'h0005_BEEF_000F};

      for (int k = 0; k < 16; k++) mem[k] = {16'(k), 16'hBEEF, 16'(k * 3)};

      bus.wb_stb = 1'b0; bus.wb_addr = '0; bus.wb_we = '0; bus.wb_din = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clkCPU);
      #1;
      chk("rst_nak", bus.wb_nak, 0);
      chk("rst_dout", bus.wb_dout, 0);
      chk("rst_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 15'h7FFF);
      chk("rst_addr", saddr, 0);
      rst_n = 1'b1;
      @(posedge clkCPU); #1;

      // Wrapper-style burst: stb held, address advanced on every accept.
      bus.wb_addr = 32'h0; bus.wb_we = 6'h0; bus.wb_stb = 1'b1;
      acc = 0; done = 0; cyc = 0; last = 0;
      while (done < 16 && cyc < 200) begin
         nak_pre = bus.wb_nak;
         stb_pre = bus.wb_stb;
         @(posedge clkCPU); #1;
         cyc++;
         if (stb_pre && !nak_pre) begin
            chk("burst_sa", saddr, acc);
            if (acc > 0) chk("burst_gap", cyc - last, 3);
            last = cyc;
            acc++;
            if (acc == 16) bus.wb_stb = 1'b0;
            else bus.wb_addr = 32'(acc * 4);
         end else if (nak_pre && !bus.wb_nak) begin
            chk("burst_dout", bus.wb_dout, {16'(done), 16'hBEEF, 16'(done * 3)});
            done++;
         end
      end
      chk("burst_done", done, 16);

      for (int v = 0; v < 8; v++) run_vec(vt[v]);

      // Reset during the first we_n-low cycle of a write to word 8.
      bus.wb_stb = 1'b1; bus.wb_addr = 32'h20; bus.wb_we = 6'h3F; bus.wb_din = 48'hDEAD_DEAD_DEAD;
      @(posedge clkCPU); #1;
      bus.wb_stb = 1'b0;
      @(posedge clkCPU); #1;
      chk("mid_we_low", we_n, 3'b000);
      rst_n = 1'b0;
      @(posedge clkCPU); #1;
      chk("mid_rst_we", we_n, 3'b111);
      chk("mid_rst_ce", ce_n, 3'b111);
      chk("mid_rst_nak", bus.wb_nak, 0);
      chk("mid_rst_addr", saddr, 0);
      chk("mid_rst_dout", bus.wb_dout, 0);
      rst_n = 1'b1;
      run_vec('{32'h0000_0020, 6'h00, 48'h0, 20'h00008, 3'b000, 3'b000, 48'h0008_BEEF_0018});

      chk("no_contention", cont_bad, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule
